// File: rtl/soc_pad_pkg.sv
// Shared definitions for SoC pad-side logic: edge-select encoding and synchroniser defaults.
package soc_pad_pkg;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_sel_e;

  localparam int unsigned SYNC_STAGES_DEFAULT = 2;

  // True when a registered rise/fall pulse is one the selected edge mode cares about.
  function automatic logic edge_match(edge_sel_e sel, logic rise, logic fall);
    logic want_rise;
    logic want_fall;
    want_rise = (sel == EDGE_RISE) || (sel == EDGE_BOTH);
    want_fall = (sel == EDGE_FALL) || (sel == EDGE_BOTH);
    return (rise && want_rise) || (fall && want_fall);
  endfunction

endpackage

// File: rtl/pad_sync.sv
// Multi-flop synchroniser for an asynchronous pad level; synchronous active-low reset.
module pad_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw level through the chain; bit 0 is the metastability-exposed stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/input_pad_conditioner.sv
// Input pad conditioner: synchronise, optionally debounce, then emit level, edge pulses and a
// sticky edge event. Build option INPUT_PAD_DEBOUNCE_EN enables the debounce counter; without
// it the accepted level follows the synchronised level one cycle later.
module input_pad_conditioner
  import soc_pad_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int unsigned DEBOUNCE_W  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_pad_in,
  input  logic [DEBOUNCE_W-1:0] i_db_limit,
  input  logic [1:0]            i_edge_sel,
  input  logic                  i_evt_clr,
  output logic                  o_level,
  output logic                  o_rise,
  output logic                  o_fall,
  output logic                  o_evt
);

  logic sync;
  logic update;

  pad_sync #(
    .STAGES(SYNC_STAGES)
  ) u_pad_sync (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .d    (i_pad_in),
    .q    (sync)
  );

`ifdef INPUT_PAD_DEBOUNCE_EN
  logic [DEBOUNCE_W-1:0] cnt;
  logic [DEBOUNCE_W-1:0] limit_m1;

  // A limit of 0 behaves as 1, so limit-1 never underflows.
  always_comb begin
    limit_m1 = '0;
    if (i_db_limit != '0) begin
      limit_m1 = i_db_limit - DEBOUNCE_W'(1);
    end
  end

  // Accept the new level once it has differed for limit consecutive cycles.
  always_comb begin
    update = (sync != o_level) && (cnt >= limit_m1);
  end

  // Count differing cycles; any agreeing cycle (glitch end) or an accept clears the count.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (update) begin
      cnt <= '0;
    end else if (sync != o_level) begin
      if (cnt != '1) begin
        cnt <= cnt + DEBOUNCE_W'(1);
      end
    end else begin
      cnt <= '0;
    end
  end
`else
  logic unused_db_limit;
  assign unused_db_limit = ^i_db_limit;

  // No debounce: every change of the synchronised level is accepted immediately.
  always_comb begin
    update = (sync != o_level);
  end
`endif

  // Registered level and single-cycle edge pulses, all produced by an accept.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_level <= 1'b0;
      o_rise  <= 1'b0;
      o_fall  <= 1'b0;
    end else begin
      if (update) begin
        o_level <= sync;
      end
      o_rise <= update && sync;
      o_fall <= update && !sync;
    end
  end

  // Sticky event: set by a selected pulse, cleared by software; set wins a collision.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_evt <= 1'b0;
    end else if (edge_match(edge_sel_e'(i_edge_sel), o_rise, o_fall)) begin
      o_evt <= 1'b1;
    end else if (i_evt_clr) begin
      o_evt <= 1'b0;
    end
  end

endmodule

// File: tb/tb_input_pad_conditioner.sv
// Self-checking bench for input_pad_conditioner: a vector table, hand-written corner sequences
// and a randomized run compared against a sample-window reference model.
module tb_input_pad_conditioner;

  localparam int unsigned SS = 2;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pad;
  logic [DW-1:0] lim;
  logic [1:0]    sel;
  logic          clr;
  logic          level, rise, fall, evt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  input_pad_conditioner #(
    .SYNC_STAGES(SS),
    .DEBOUNCE_W (DW)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_pad_in  (pad),
    .i_db_limit(lim),
    .i_edge_sel(sel),
    .i_evt_clr (clr),
    .o_level   (level),
    .o_rise    (rise),
    .o_fall    (fall),
    .o_evt     (evt)
  );

  // Effective number of stable cycles needed for acceptance in this build.
  function automatic int eff(int l);
`ifdef INPUT_PAD_DEBOUNCE_EN
    return (l == 0) ? 1 : l;
`else
    return 1;
`endif
  endfunction

  // Reference model: pad samples delayed SS cycles; a new level is accepted when the most recent
  // eff(limit) synchronised samples since the last acceptance all differ from the current level.
  bit pipe[$];
  bit hist[$];
  bit m_level, m_rise, m_fall, m_evt;

  task automatic model_reset();
    pipe.delete();
    for (int i = 0; i < int'(SS); i++) pipe.push_back(1'b0);
    hist.delete();
    m_level = 0; m_rise = 0; m_fall = 0; m_evt = 0;
  endtask

  task automatic model_edge();
    bit s, acc, ne;
    int run;
    if (!rst_n) begin
      model_reset();
      return;
    end
    s = pipe[SS-1];
    hist.push_back(s);
    if (hist.size() > 64) void'(hist.pop_front());
    run = 0;
    for (int i = hist.size() - 1; i >= 0 && hist[i] != m_level; i--) run++;
    acc = (run >= eff(int'(lim)));
    ne = m_evt;
    if ((m_rise && sel[0]) || (m_fall && sel[1])) ne = 1'b1;
    else if (clr) ne = 1'b0;
    m_rise = acc && s;
    m_fall = acc && !s;
    m_evt  = ne;
    if (acc) begin
      m_level = s;
      hist.delete();
    end
    pipe.push_front(pad);
    void'(pipe.pop_back());
  endtask

  // One clock: model follows the active edge, outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0b expected=%0b", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Clock until the requested pulse is seen; n is the edge count, or -1 on timeout.
  task automatic wait_pulse(input bit want_fall, output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if ((want_fall ? fall : rise) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  typedef struct {
    bit       rst_n;
    bit       pad;
    bit [1:0] sel;
    bit       clr;
    bit       level;
    bit       rise;
    bit       fall;
    bit       evt;
  } vec_t;

  function automatic vec_t mk(bit r, bit p, bit [1:0] s, bit c, bit l, bit ri, bit f, bit e);
    vec_t v;
    v.rst_n = r; v.pad = p; v.sel = s; v.clr = c;
    v.level = l; v.rise = ri; v.fall = f; v.evt = e;
    return v;
  endfunction

  vec_t vecs[16];

  initial begin
    int n;
    bit seen;
    bit exp_rise;

    // Limit 1 throughout, so these expectations hold with or without the debounce counter.
    vecs[0]  = mk(0, 0, 2'b11, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 2'b11, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 1, 2'b11, 0, 0, 0, 0, 0);
    vecs[3]  = mk(1, 1, 2'b11, 0, 0, 0, 0, 0);
    vecs[4]  = mk(1, 1, 2'b11, 0, 1, 1, 0, 0);
    vecs[5]  = mk(1, 0, 2'b11, 0, 1, 0, 0, 1);
    vecs[6]  = mk(1, 0, 2'b11, 0, 1, 0, 0, 1);
    vecs[7]  = mk(1, 0, 2'b11, 0, 0, 0, 1, 1);
    vecs[8]  = mk(1, 0, 2'b11, 1, 0, 0, 0, 1);
    vecs[9]  = mk(1, 0, 2'b11, 1, 0, 0, 0, 0);
    vecs[10] = mk(1, 1, 2'b01, 0, 0, 0, 0, 0);
    vecs[11] = mk(1, 0, 2'b01, 0, 0, 0, 0, 0);
    vecs[12] = mk(1, 0, 2'b01, 0, 1, 1, 0, 0);
    vecs[13] = mk(1, 0, 2'b01, 0, 0, 0, 1, 1);
    vecs[14] = mk(1, 0, 2'b01, 0, 0, 0, 0, 1);
    vecs[15] = mk(1, 0, 2'b00, 1, 0, 0, 0, 0);

    rst_n = 0; pad = 0; lim = 16'd1; sel = 2'b00; clr = 0;
    model_reset();

    for (int i = 0; i < 16; i++) begin
      rst_n = vecs[i].rst_n; pad = vecs[i].pad; sel = vecs[i].sel; clr = vecs[i].clr;
      tick();
      check($sformatf("vec%0d.level", i), level, vecs[i].level);
      check($sformatf("vec%0d.rise", i), rise, vecs[i].rise);
      check($sformatf("vec%0d.fall", i), fall, vecs[i].fall);
      check($sformatf("vec%0d.evt", i), evt, vecs[i].evt);
    end
    clr = 0;

    // Pad held high through reset gives exactly one rise after release.
    rst_n = 0; pad = 1; lim = 16'd3;
    ticks(5);
    check("rst_hold.level", level, 1'b0);
    rst_n = 1;
    for (int k = 1; k <= int'(SS) + eff(3); k++) begin
      tick();
      if (k < int'(SS) + eff(3)) begin
        check($sformatf("rst_rel%0d.level", k), level, 1'b0);
        check($sformatf("rst_rel%0d.rise", k), rise, 1'b0);
      end else begin
        check("rst_rel.level", level, 1'b1);
        check("rst_rel.rise", rise, 1'b1);
      end
    end
    tick();
    check("rst_rel.rise_width", rise, 1'b0);

    // Clean rising edge latency and pulse width.
    pad = 0; lim = 16'd4;
    ticks(12);
    pad = 1;
    wait_pulse(1'b0, n);
    check_int("clean_rise.latency", n, int'(SS) + eff(4));
    tick();
    check("clean_rise.width", rise, 1'b0);

    // Three-cycle glitch against limit 4.
    pad = 0;
    ticks(12);
    pad = 1;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      if (k == 3) pad = 0;
      tick();
      if (rise === 1'b1) seen = 1;
    end
    check("glitch.rise_seen", seen, (eff(4) <= 3) ? 1'b1 : 1'b0);
    check("glitch.level", level, 1'b0);
    pad = 1;
    wait_pulse(1'b0, n);
    check_int("glitch.cnt_cleared_latency", n, int'(SS) + eff(4));

    // Sticky fall event, rise ignored, set/clear collision, lone clear.
    lim = 16'd2; sel = 2'b10; clr = 1;
    tick();
    clr = 0;
    pad = 0;
    wait_pulse(1'b1, n);
    check("evt.first_fall_seen", n > 0, 1'b1);
    tick();
    check("evt.set_on_fall", evt, 1'b1);
    clr = 1;
    tick();
    clr = 0;
    check("evt.cleared", evt, 1'b0);
    pad = 1;
    wait_pulse(1'b0, n);
    tick();
    check("evt.rise_ignored", evt, 1'b0);
    pad = 0;
    wait_pulse(1'b1, n);
    check("evt.second_fall_seen", n > 0, 1'b1);
    clr = 1;
    tick();
    check("evt.collision_set_wins", evt, 1'b1);
    tick();
    check("evt.lone_clear", evt, 1'b0);
    clr = 0; sel = 2'b00;

    // Limit shrinks from 10 to 2 when six differing cycles have been counted.
    lim = 16'd10;
    ticks(20);
    pad = 1;
    ticks(8);
    check("shrink.before", level, (int'(SS) + eff(10) <= 8) ? 1'b1 : 1'b0);
    lim = 16'd2;
    exp_rise = (int'(SS) + eff(10) > 8);
    tick();
    check("shrink.level", level, 1'b1);
    check("shrink.rise", rise, exp_rise);

    // Randomized run against the reference model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) pad = ~pad;
      if ($urandom_range(0, 149) == 0) lim = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 49) == 0) sel = 2'($urandom_range(0, 3));
      clr = ($urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 499) != 0);
      tick();
      check($sformatf("rand%0d.level", c), level, m_level);
      check($sformatf("rand%0d.rise", c), rise, m_rise);
      check($sformatf("rand%0d.fall", c), fall, m_fall);
      check($sformatf("rand%0d.evt", c), evt, m_evt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
